// File: rtl/serial_receiver.sv
// Serial-to-parallel receiver: rebuilds an MSB-first word by sampling at mid-bit,
// then presents it on data_out behind a valid/ack handshake.
module serial_receiver #(
   parameter int WIDTH      = 12,
   parameter int BIT_CYCLES = 50_000_000
) (
   input  logic                         clock,
   input  logic                         reset_n,
   input  logic                         start,
   input  logic                         serial_in,
   input  logic                         ack,
   output logic [WIDTH-1:0]             data_out,
   output logic                         valid,
   output logic                         busy,
   output logic [$clog2(WIDTH+1)-1:0]   bit_count
);

   localparam int BCW   = $clog2(WIDTH + 1);
   localparam int CNT_W = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
   localparam int HALF  = BIT_CYCLES / 2;

   localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(BIT_CYCLES - 1);
   localparam logic [BCW-1:0]   LAST_BIT  = BCW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ALIGN = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [WIDTH-1:0]   shift_q;
   logic [WIDTH-1:0]   data_q;
   logic               valid_q;
   logic               busy_q;
   logic [BCW-1:0]     bit_cnt_q;

   logic [WIDTH-1:0]   shift_d;
   logic [CNT_W-1:0]   cnt_dec_d;
   logic               cnt_zero_d;

   // Shared next values: shift-in word, counter decrement, sample strobe.
   always_comb begin
      shift_d    = {shift_q[WIDTH-2:0], serial_in};
      cnt_dec_d  = cnt_q - CNT_W'(1);
      cnt_zero_d = (cnt_q == {CNT_W{1'b0}});
   end

   // Capture FSM; every output is a register updated alongside the state.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         cnt_q     <= {CNT_W{1'b0}};
         shift_q   <= {WIDTH{1'b0}};
         data_q    <= {WIDTH{1'b0}};
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         bit_cnt_q <= {BCW{1'b0}};
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= ALIGN;
                  cnt_q   <= HALF_LOAD;
                  busy_q  <= 1'b1;
               end else begin
                  busy_q  <= 1'b0;
               end
            end
            ALIGN: begin
               if (cnt_zero_d) begin
                  shift_q   <= shift_d;
                  bit_cnt_q <= BCW'(1);
                  cnt_q     <= BIT_LOAD;
                  state_q   <= SHIFT;
               end else begin
                  cnt_q     <= cnt_dec_d;
               end
            end
            SHIFT: begin
               if (cnt_zero_d) begin
                  shift_q <= shift_d;
                  // Final sample completes the word on this same edge.
                  if (bit_cnt_q == LAST_BIT) begin
                     data_q    <= shift_d;
                     valid_q   <= 1'b1;
                     busy_q    <= 1'b0;
                     bit_cnt_q <= {BCW{1'b0}};
                     state_q   <= DONE;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + BCW'(1);
                     cnt_q     <= BIT_LOAD;
                  end
               end else begin
                  cnt_q <= cnt_dec_d;
               end
            end
            DONE: begin
               if (ack) begin
                  valid_q <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  valid_q <= 1'b1;
               end
            end
            default: begin
               state_q   <= IDLE;
               valid_q   <= 1'b0;
               busy_q    <= 1'b0;
               bit_cnt_q <= {BCW{1'b0}};
            end
         endcase
      end
   end

   assign data_out  = data_q;
   assign valid     = valid_q;
   assign busy      = busy_q;
   assign bit_count = bit_cnt_q;

endmodule

// File: doc/serial_receiver.md
# serial_receiver

Serial-to-parallel receiver that reconstructs a WIDTH-bit word from the MSB-first serial stream produced by the 12-bit parallel-load shift register. It runs on the fast system clock, times each bit with an internal cycle counter, samples at mid-bit, and hands the assembled word to the consumer through a valid/ack handshake. It sits on the receive side of the pattern link, feeding the hex display decode and the comparison logic.

## Interface

- WIDTH, 12, bits per word; must be ≥ 2.
- BIT_CYCLES, 50_000_000, clock cycles per serial bit (one shift period of the transmitter); must be ≥ 2.

Ports:

- clock  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  level, sampled in IDLE; begins capture aligned to the current edge as bit-0 leading edge.
- serial_in  in  1  serial data, MSB first, synchronous to clock.
- ack  in  1  consumer accepts data_out; honoured only while valid=1.
- data_out  out  WIDTH  last completed word, held until next completion.
- valid  out  1  high while a completed word awaits ack.
- busy  out  1  high in ALIGN and SHIFT.
- bit_count  out  clog2(WIDTH+1)  bits sampled so far in the current capture.

## Operation

- States: IDLE, ALIGN, SHIFT, DONE. Encoding is free; only the outputs are observable.
- Reset (async, reset_n=0): state IDLE, shift register 0, counter 0, bit_count 0, data_out 0, valid 0, busy 0. Reset asserted mid-capture discards the partial word.
- IDLE: if start=1 at an edge, the block goes to ALIGN and loads the counter with HALF-1, where HALF = BIT_CYCLES/2 (integer division).
- ALIGN: the counter decrements each cycle. At the edge where it reads 0, the block samples serial_in into the shift register LSB (shifting left), sets bit_count to 1, loads the counter with BIT_CYCLES-1, and goes to SHIFT.
- SHIFT: the counter decrements each cycle. At each edge where it reads 0, the block shifts in serial_in, increments bit_count and reloads the counter with BIT_CYCLES-1. The sample that brings bit_count to WIDTH writes {shift_reg[WIDTH-2:0], serial_in} to data_out on the same edge, sets valid=1, resets bit_count to 0 and moves to DONE.
- DONE: valid=1. ack=1 at an edge moves the block to IDLE, and valid reads 0 after that edge. data_out is unchanged.
- start is ignored in ALIGN, SHIFT and DONE. A new capture requires IDLE, so it can begin no earlier than the edge after the ack edge.
- ack is ignored outside DONE.
- busy = (state==ALIGN or SHIFT), derived from registered state.
- The first bit received lands in data_out[WIDTH-1]. This matches the transmitter's MSB-first order.

## Timing

- Let E0 be the edge at which start is sampled high in IDLE.
- Bit k (k=0..WIDTH-1) is sampled at edge E0 + HALF + k·BIT_CYCLES.
- data_out and valid update at edge E0 + HALF + (WIDTH-1)·BIT_CYCLES.
- With BIT_CYCLES=4 and WIDTH=12: samples occur at E0+2, +6, …, +46, and valid=1 is visible after E0+46.
- Counter width is clog2(BIT_CYCLES). There is no wrap beyond the reload value.
- Odd BIT_CYCLES: HALF rounds down, and the sample point falls ≤ ½ cycle early.
- Ack latency: 1 edge. The earliest restart is 2 edges after completion (ack edge, then start edge).

## Test plan

- **Reset values.** Assert reset_n=0 asynchronously mid-cycle. Then data_out=0, valid=0, busy=0 and bit_count=0 immediately, with no clock edge required.
- **Basic word.** BIT_CYCLES=4. Pulse start, then drive 12'hA5C MSB-first, each bit held 4 cycles starting at E0. Then busy=1 from E0+1, valid=1 after E0+46, data_out=12'hA5C, busy=0.
- **Handshake.** Hold ack=0 for 20 cycles after valid. valid stays 1 and data_out stays 12'hA5C. Then ack=1 for one cycle: valid=0 next cycle and data_out is still 12'hA5C. Then start with all-ones input: data_out=12'hFFF.
- **Ignored controls.** Toggle start during SHIFT and pulse ack during SHIFT and IDLE. The sample timing is unchanged, no spurious valid occurs, and the captured word is correct.
- **Reset mid-capture.** Apply reset_n=0 after 5 bits, then release, then send 12'h001. data_out=12'h001 with no residue from the aborted word, and bit_count counts 1..11 and returns to 0.
- **Odd period.** BIT_CYCLES=5: samples occur at E0+2+5k, and 12'h3C3 is received correctly.
